ad_fre_hyst: RTL and testbench

AD_FRE_HYST -- requirements
Module: ad_fre_hyst

---
 rtl/ad_fre_hyst.sv | 160 ++++++++++++++++
 tb/tb_ad_fre_hyst.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ad_fre_hyst.sv
// Frequency meter for an ADC-sampled waveform: a windowed peak tracker places a
// hysteresis comparator around the signal midpoint, and rising edges are counted per gate.
module ad_fre_hyst #(
   parameter int AD_W     = 10,
   parameter int CNT_W    = 24,
   parameter int GATE_CYC = 1000000,
   parameter int PEAK_WIN = 65536,
   parameter int HYST     = 4
) (
   input  logic             clk_div10,
   input  logic             rst_n,
   input  logic             en,
   input  logic [AD_W-1:0]  ad_in,
   output logic [CNT_W-1:0] fre,
   output logic             fre_vld,
   output logic             ovf,
   output logic [AD_W-1:0]  vpp,
   output logic             sig_lost,
   output logic             sq_out
);

   localparam int GC_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
   localparam int PW_W = (PEAK_WIN > 1) ? $clog2(PEAK_WIN) : 1;

   localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYC - 1);
   localparam logic [GC_W-1:0]  GATE_ZERO = GC_W'(1'b0);
   localparam logic [GC_W-1:0]  GATE_ONE  = GC_W'(1'b1);
   localparam logic [PW_W-1:0]  WIN_LAST  = PW_W'(PEAK_WIN - 1);
   localparam logic [PW_W-1:0]  WIN_ZERO  = PW_W'(1'b0);
   localparam logic [PW_W-1:0]  WIN_ONE   = PW_W'(1'b1);
   localparam logic [AD_W-1:0]  AD_MID    = {1'b1, {(AD_W-1){1'b0}}};
   localparam logic [AD_W-1:0]  AD_ZERO   = {AD_W{1'b0}};
   localparam logic [AD_W-1:0]  HYST2     = AD_W'(2 * HYST);
   localparam logic [AD_W:0]    AD_MAX_X  = {1'b0, {AD_W{1'b1}}};
   localparam logic [AD_W:0]    ZERO_X    = {(AD_W+1){1'b0}};
   localparam logic [AD_W:0]    HYST_X    = (AD_W+1)'(HYST);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

   logic [PW_W-1:0]  win_cnt_r;
   logic [AD_W-1:0]  run_max_r, run_min_r, held_max_r, held_min_r;
   logic [AD_W-1:0]  run_max_nxt_s, run_min_nxt_s, vpp_nxt_s;
   logic [AD_W:0]    sum_s, zero_s, thr_hi_raw_s, thr_hi_s, thr_lo_s, ad_x_s;
   logic             sq_d_r, sq_nxt_s;
   logic [GC_W-1:0]  gate_cnt_r;
   logic [CNT_W-1:0] edge_cnt_r, cnt_inc_s;
   logic             ovf_g_r, edge_s, cnt_sat_s, sat_hit_s, gate_last_s;

   // Running extremes, midpoint and saturating hysteresis thresholds
   always_comb begin
      run_max_nxt_s = run_max_r;
      run_min_nxt_s = run_min_r;
      if (ad_in > run_max_r) run_max_nxt_s = ad_in;
      else                   run_max_nxt_s = run_max_r;
      if (ad_in < run_min_r) run_min_nxt_s = ad_in;
      else                   run_min_nxt_s = run_min_r;
      vpp_nxt_s    = run_max_nxt_s - run_min_nxt_s;
      sum_s        = {1'b0, held_max_r} + {1'b0, held_min_r};
      zero_s       = {1'b0, sum_s[AD_W:1]};
      thr_hi_raw_s = zero_s + HYST_X;
      ad_x_s       = {1'b0, ad_in};
      if (thr_hi_raw_s > AD_MAX_X) thr_hi_s = AD_MAX_X;
      else                         thr_hi_s = thr_hi_raw_s;
      if (zero_s < HYST_X) thr_lo_s = ZERO_X;
      else                 thr_lo_s = zero_s - HYST_X;
   end

   // Comparator next state; frozen while disabled or while the amplitude is too small
   always_comb begin
      sq_nxt_s = sq_out;
      if (en && !sig_lost) begin
         if (ad_x_s > thr_hi_s)      sq_nxt_s = 1'b1;
         else if (ad_x_s < thr_lo_s) sq_nxt_s = 1'b0;
         else                        sq_nxt_s = sq_out;
      end else begin
         sq_nxt_s = sq_out;
      end
   end

   // Edge detect and saturating increment of the per-gate edge count
   always_comb begin
      edge_s      = sq_out & ~sq_d_r;
      cnt_sat_s   = (edge_cnt_r == CNT_MAX);
      sat_hit_s   = edge_s & cnt_sat_s;
      gate_last_s = (gate_cnt_r == GATE_LAST);
      if (edge_s && !cnt_sat_s) cnt_inc_s = edge_cnt_r + CNT_ONE;
      else                      cnt_inc_s = edge_cnt_r;
   end

   // Peak tracker: windowed min/max with held results and amplitude status
   always_ff @(posedge clk_div10) begin
      if (!rst_n) begin
         win_cnt_r  <= WIN_ZERO;
         run_max_r  <= AD_MID;
         run_min_r  <= AD_MID;
         held_max_r <= AD_MID;
         held_min_r <= AD_MID;
         vpp        <= AD_ZERO;
         sig_lost   <= 1'b1;
      end else if (en) begin
         if (win_cnt_r == WIN_LAST) begin
            win_cnt_r  <= WIN_ZERO;
            held_max_r <= run_max_nxt_s;
            held_min_r <= run_min_nxt_s;
            run_max_r  <= ad_in;
            run_min_r  <= ad_in;
            vpp        <= vpp_nxt_s;
            sig_lost   <= (vpp_nxt_s < HYST2);
         end else begin
            win_cnt_r <= win_cnt_r + WIN_ONE;
            run_max_r <= run_max_nxt_s;
            run_min_r <= run_min_nxt_s;
         end
      end else begin
         win_cnt_r <= WIN_ZERO;
      end
   end

   // Recovered square wave and its one-cycle-delayed copy
   always_ff @(posedge clk_div10) begin
      if (!rst_n) begin
         sq_out <= 1'b0;
         sq_d_r <= 1'b0;
      end else begin
         sq_out <= sq_nxt_s;
         sq_d_r <= sq_out;
      end
   end

   // Gate timing; the closing cycle's edge lands in the published result, not the next gate
   always_ff @(posedge clk_div10) begin
      if (!rst_n) begin
         gate_cnt_r <= GATE_ZERO;
         edge_cnt_r <= CNT_ZERO;
         ovf_g_r    <= 1'b0;
         fre        <= CNT_ZERO;
         ovf        <= 1'b0;
         fre_vld    <= 1'b0;
      end else if (!en) begin
         gate_cnt_r <= GATE_ZERO;
         edge_cnt_r <= CNT_ZERO;
         ovf_g_r    <= 1'b0;
         fre_vld    <= 1'b0;
      end else if (gate_last_s) begin
         gate_cnt_r <= GATE_ZERO;
         edge_cnt_r <= CNT_ZERO;
         ovf_g_r    <= 1'b0;
         fre        <= cnt_inc_s;
         ovf        <= ovf_g_r | sat_hit_s;
         fre_vld    <= 1'b1;
      end else begin
         gate_cnt_r <= gate_cnt_r + GATE_ONE;
         edge_cnt_r <= cnt_inc_s;
         ovf_g_r    <= ovf_g_r | sat_hit_s;
         fre_vld    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ad_fre_hyst.sv
// Bench for ad_fre_hyst: two instances (24-bit and 4-bit counters) share stimulus;
// per-gate expectations are queued with the cycle their fre_vld pulse is due.
module tb_ad_fre_hyst;

   logic        clk_div10 = 1'b0;
   logic        rst_n, en;
   logic [9:0]  ad_in;
   logic [23:0] fre;
   logic        fre_vld, ovf, sig_lost, sq_out;
   logic [9:0]  vpp;
   logic [3:0]  fre4;
   logic        fre_vld4, ovf4, sig_lost4, sq_out4;
   logic [9:0]  vpp4;

   always #5 clk_div10 = ~clk_div10;

   ad_fre_hyst #(.AD_W(10), .CNT_W(24), .GATE_CYC(100), .PEAK_WIN(50), .HYST(4)) u_dut (
      .clk_div10(clk_div10), .rst_n(rst_n), .en(en), .ad_in(ad_in),
      .fre(fre), .fre_vld(fre_vld), .ovf(ovf), .vpp(vpp), .sig_lost(sig_lost), .sq_out(sq_out));

   ad_fre_hyst #(.AD_W(10), .CNT_W(4), .GATE_CYC(100), .PEAK_WIN(50), .HYST(4)) u_dut4 (
      .clk_div10(clk_div10), .rst_n(rst_n), .en(en), .ad_in(ad_in),
      .fre(fre4), .fre_vld(fre_vld4), .ovf(ovf4), .vpp(vpp4), .sig_lost(sig_lost4), .sq_out(sq_out4));

   typedef struct {
      int unsigned at;
      bit          chk;
      logic [23:0] fre;
      logic        ovf;
      logic [3:0]  fre4;
      logic        ovf4;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_x;
   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;
   int unsigned base = 0;
   int          e = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk_div10) cyc <= cyc + 1;

   // Scoreboard: every fre_vld pulse must match the oldest queued gate
   always @(negedge clk_div10) begin
      if (fre_vld || fre_vld4) begin
         if (sb_q.size() == 0) begin
            check("vld_unexp", 32'(fre_vld), 32'd0);
            check("vld4_unexp", 32'(fre_vld4), 32'd0);
         end else begin
            mon_x = sb_q.pop_front();
            check("vld_at", cyc, mon_x.at);
            check("vld", 32'(fre_vld), 32'd1);
            check("vld4", 32'(fre_vld4), 32'd1);
            if (mon_x.chk) begin
               check("fre", 32'(fre), 32'(mon_x.fre));
               check("ovf", 32'(ovf), 32'(mon_x.ovf));
               check("fre4", 32'(fre4), 32'(mon_x.fre4));
               check("ovf4", 32'(ovf4), 32'(mon_x.ovf4));
            end
         end
      end
   end

   // One clock: drive at the falling edge, return at the next falling edge
   task automatic tick(input logic [9:0] a);
      ad_in = a;
      @(posedge clk_div10);
      @(negedge clk_div10);
      e++;
   endtask

   task automatic expect_gate(input int k, input bit chk, input logic [23:0] f, input logic o,
                              input logic [3:0] f4, input logic o4);
      exp_t x;
      x.at   = base + 32'(99 + 100 * k);
      x.chk  = chk;
      x.fre  = f;
      x.ovf  = o;
      x.fre4 = f4;
      x.ovf4 = o4;
      sb_q.push_back(x);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(ad_in);
      check("rst_fre", 32'(fre), 32'd0);
      check("rst_vld", 32'(fre_vld), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_vpp", 32'(vpp), 32'd0);
      check("rst_lost", 32'(sig_lost), 32'd1);
      check("rst_sq", 32'(sq_out), 32'd0);
      check("rst_fre4", 32'(fre4), 32'd0);
      rst_n = 1'b1;
      e     = 0;
      base  = cyc + 1;
   endtask

   function automatic logic [9:0] sqw(input int idx, input int half);
      return (((idx / half) % 2) == 1) ? 10'd1000 : 10'd0;
   endfunction

   function automatic logic [9:0] noisy(input int idx);
      int unsigned v;
      v = $urandom_range(6, 0);
      return (((idx / 10) % 2) == 1) ? 10'(994 + v) : 10'(v);
   endfunction

   function automatic logic [9:0] g99(input int idx);
      int c, g;
      bit hi;
      c  = idx % 100;
      g  = idx / 100;
      hi = (c >= 20 && c < 30) || (c >= 60 && c < 70) || ((g % 2) == 0 && c >= 98);
      return hi ? 10'd1000 : 10'd0;
   endfunction

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      ad_in = 10'd0;
      @(negedge clk_div10);

      // square 0/1000, period 10
      do_reset();
      for (int k = 0; k < 4; k++) expect_gate(k, k >= 2, 24'd10, 1'b0, 4'd10, 1'b0);
      repeat (401) tick(sqw(e, 5));
      check("sq10_sb_empty", 32'(sb_q.size()), 32'd0);
      check("sq10_vpp", 32'(vpp), 32'd1000);
      check("sq10_lost", 32'(sig_lost), 32'd0);
      check("sq10_vpp4", 32'(vpp4), 32'd1000);

      // constant mid-scale input
      do_reset();
      for (int k = 0; k < 2; k++) expect_gate(k, 1'b1, 24'd0, 1'b0, 4'd0, 1'b0);
      repeat (201) tick(10'd512);
      check("const_sb_empty", 32'(sb_q.size()), 32'd0);
      check("const_vpp", 32'(vpp), 32'd0);
      check("const_lost", 32'(sig_lost), 32'd1);
      check("const_sq", 32'(sq_out), 32'd0);

      // period-20 square with small noise
      do_reset();
      for (int k = 0; k < 4; k++) expect_gate(k, k >= 2, 24'd5, 1'b0, 4'd5, 1'b0);
      repeat (401) tick(noisy(e));
      check("noise_sb_empty", 32'(sb_q.size()), 32'd0);
      check("noise_lost", 32'(sig_lost), 32'd0);

      // period-2 square: 50 edges per gate saturates the 4-bit counter
      do_reset();
      for (int k = 0; k < 4; k++) expect_gate(k, k >= 2, 24'd50, 1'b0, 4'd15, 1'b1);
      repeat (401) tick(sqw(e, 1));
      check("p2_sb_empty", 32'(sb_q.size()), 32'd0);

      // edge on gate cycle 99 in even gates only
      do_reset();
      for (int k = 0; k < 6; k++)
         expect_gate(k, k >= 2, ((k % 2) == 0) ? 24'd3 : 24'd2, 1'b0,
                     ((k % 2) == 0) ? 4'd3 : 4'd2, 1'b0);
      repeat (601) tick(g99(e));
      check("g99_sb_empty", 32'(sb_q.size()), 32'd0);

      // reset at gate cycle 40 discards the partial gate
      do_reset();
      for (int k = 0; k < 3; k++) expect_gate(k, k >= 2, 24'd10, 1'b0, 4'd10, 1'b0);
      repeat (340) tick(sqw(e, 5));
      check("mid_pre_sb_empty", 32'(sb_q.size()), 32'd0);
      do_reset();
      for (int k = 0; k < 2; k++) expect_gate(k, k >= 1, 24'd10, 1'b0, 4'd10, 1'b0);
      repeat (201) tick(sqw(e, 5));
      check("mid_sb_empty", 32'(sb_q.size()), 32'd0);

      // en low for 30 cycles mid-gate
      do_reset();
      for (int k = 0; k < 3; k++) expect_gate(k, k >= 2, 24'd10, 1'b0, 4'd10, 1'b0);
      repeat (330) tick(sqw(e, 5));
      en = 1'b0;
      repeat (30) tick(sqw(e, 5));
      check("en0_fre", 32'(fre), 32'd10);
      check("en0_vld", 32'(fre_vld), 32'd0);
      check("en0_vpp", 32'(vpp), 32'd1000);
      check("en0_sb_empty", 32'(sb_q.size()), 32'd0);
      en   = 1'b1;
      base = cyc + 1;
      for (int k = 0; k < 2; k++) expect_gate(k, k >= 1, 24'd10, 1'b0, 4'd10, 1'b0);
      repeat (201) tick(sqw(e, 5));
      check("en1_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
